// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU clients and alu_arbiter.
// Clients sit on the master side and the arbiter on the slave side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  // client 0
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [2:0]            req0_op;
  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_result;
  logic                  rsp0_eq;
  // client 1
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [2:0]            req1_op;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_result;
  logic                  rsp1_eq;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_eq,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_eq
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_eq,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_eq
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two clients share one combinational ALU.
// The granted request is evaluated in its accept cycle and the result is
// held in a register until the owning client takes it.

// Shared combinational ALU. Unused opcodes answer with result 0, eq 0.
module alu_arbiter_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq
);
  // opcode decode; add/sub simply wrap at the operand width
  always_comb begin
    result = '0;
    eq     = 1'b0;
    case (op)
      3'b000: begin result = a + b; eq = (a == b); end
      3'b001: begin result = a - b; eq = (a == b); end
      3'b010: begin result = a & b; eq = (a == b); end
      3'b011: begin result = a | b; eq = (a == b); end
      3'b100: begin result = a ^ b; eq = (a == b); end
      default: ;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [2:0]            op;
  } req_t;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] result;
  logic                  eq;
  logic                  owner;
  logic                  last_grant;
  logic [1:0]            rsp_valid;

  req_t [1:0]            req;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_ready;
  logic [1:0]            grant;
  logic                  can_accept;
  logic                  accept;
  logic                  sel;
  req_t                  sel_req;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_eq;

  assign req[0]    = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op};
  assign req[1]    = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op};
  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // round-robin pick: under contention the client that did not win last
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // a slot is free when idle, or when the held result leaves this cycle
  assign can_accept = (state == IDLE) | ((state == RESP) & rsp_ready[owner]);
  assign req_ready  = grant & {2{can_accept}};
  assign accept     = |req_ready;
  assign sel        = req_ready[1];
  assign sel_req    = sel ? req[1] : req[0];

  alu_arbiter_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (sel_req.a),
    .b      (sel_req.b),
    .op     (sel_req.op),
    .result (alu_result),
    .eq     (alu_eq)
  );

  // result/ownership FSM; response valids are registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 2'b00;
      result     <= '0;
      eq         <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            result     <= alu_result;
            eq         <= alu_eq;
            owner      <= sel;
            last_grant <= sel;
            rsp_valid  <= sel ? 2'b10 : 2'b01;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            if (accept) begin
              result     <= alu_result;
              eq         <= alu_eq;
              owner      <= sel;
              last_grant <= sel;
              rsp_valid  <= sel ? 2'b10 : 2'b01;
            end else begin
              state     <= IDLE;
              rsp_valid <= 2'b00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = req_ready[0];
  assign bus.req1_ready  = req_ready[1];
  assign bus.rsp0_valid  = rsp_valid[0];
  assign bus.rsp1_valid  = rsp_valid[1];
  assign bus.rsp0_result = result;
  assign bus.rsp1_result = result;
  assign bus.rsp0_eq     = eq;
  assign bus.rsp1_eq     = eq;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs change on the falling edge,
// combinational readies are sampled 1ns later, registered outputs 1ns
// after the rising edge.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.DATA_WIDTH(32)) bus ();
  alu_arbiter #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b%b exp 00", bus.rsp1_valid, bus.rsp0_valid);
    end
    checks++;
    if (bus.rsp0_result !== 32'h0 || bus.rsp0_eq !== 1'b0) begin
      errors++; $display("FAIL reset_result: got %h/%b exp 0/0", bus.rsp0_result, bus.rsp0_eq);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b exp 00", bus.req1_ready, bus.req0_ready);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive0(1'b1, 32'd5, 32'd3, 3'b000);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready: got %b%b exp 01", bus.req1_ready, bus.req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_result !== 32'd8 || bus.rsp0_eq !== 1'b0) begin
      errors++; $display("FAIL basic_rsp: got v=%b%b r=%h eq=%b exp v=01 r=8 eq=0",
                         bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_eq);
    end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (bus.rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL basic_taken: got rsp0_valid=%b exp 0", bus.rsp0_valid);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    drive0(1'b1, 32'h10, 32'h10, 3'b001);
    drive1(1'b1, 32'h10, 32'h10, 3'b001);
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_g) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b%b exp %b", k, bus.req1_ready, bus.req0_ready, exp_g);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp1_valid, bus.rsp0_valid} !== exp_g || bus.rsp0_result !== 32'h0 || bus.rsp0_eq !== 1'b1) begin
        errors++; $display("FAIL fair_rsp[%0d]: got v=%b%b r=%h eq=%b exp v=%b r=0 eq=1",
                           k, bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_eq, exp_g);
      end
      @(negedge clk);
    end
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    drive1(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b000);
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_ready: got %b exp 1", bus.req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'h0 || bus.rsp1_eq !== 1'b0) begin
      errors++; $display("FAIL wrap_add: got v=%b r=%h eq=%b exp v=1 r=0 eq=0", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_eq);
    end
    @(negedge clk);
    drive1(1'b1, 32'h0, 32'h1, 3'b001);
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_b2b_ready: got %b exp 1", bus.req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'hFFFF_FFFF || bus.rsp1_eq !== 1'b0) begin
      errors++; $display("FAIL wrap_sub: got v=%b r=%h eq=%b exp v=1 r=ffffffff eq=0", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_eq);
    end
    @(negedge clk);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.rsp0_ready = 1'b0;
    drive0(1'b1, 32'd2, 32'd2, 3'b010);
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    drive1(1'b1, 32'd9, 32'd4, 3'b100);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b exp 0", k, bus.req1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd2 || bus.rsp0_eq !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b r=%h eq=%b exp v=1 r=2 eq=1", k, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_eq);
      end
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got %b exp 1", bus.req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_result !== 32'd13 || bus.rsp1_eq !== 1'b0) begin
      errors++; $display("FAIL bp_rsp1: got v=%b%b r=%h eq=%b exp v=10 r=d eq=0",
                         bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_result, bus.rsp1_eq);
    end
    @(negedge clk);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_bad_op();
    bus.rsp0_ready = 1'b0;
    drive0(1'b1, 32'd7, 32'd7, 3'b110);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++; $display("FAIL badop_ready: got %b exp 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'h0 || bus.rsp0_eq !== 1'b0) begin
      errors++; $display("FAIL badop_rsp: got v=%b r=%h eq=%b exp v=1 r=0 eq=0", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_eq);
    end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
  endtask

  // enters with client 0 holding an untaken result; last grant was client 0
  task automatic test_reset_mid();
    rst = 1'b1;
    drive0(1'b1, 32'd1, 32'd1, 3'b000);
    drive1(1'b1, 32'd1, 32'd1, 3'b000);
    @(posedge clk); #1;
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid: got %b%b exp 00", bus.rsp1_valid, bus.rsp0_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_grant: got %b%b exp 01", bus.req1_ready, bus.req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 32'd2 || bus.rsp0_eq !== 1'b1) begin
      errors++; $display("FAIL rstmid_rsp: got v=%b r=%h eq=%b exp v=1 r=2 eq=1", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_eq);
    end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
  endtask

  initial begin
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    test_reset();
    test_basic();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_bad_op();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
